fp_madd: RTL and testbench

FP_MADD -- requirements
Module: fp_madd

---
 rtl/fp_madd.sv | 200 ++++++++++++++++++++
 tb/tb_fp_madd.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_madd.sv
// Single-cycle binary32 fused multiply-add (a*b+c) with registered result and flags.
// Define FP_MADD_RMODE_EN to honour r_mode; otherwise every result rounds to nearest-even.
module fp_madd #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fp_a,
  input  logic [31:0] fp_b,
  input  logic [31:0] fp_c,
  input  logic [2:0]  r_mode,
  output logic [31:0] fp_result,
  output logic        overflow,
  output logic        underflow
);

  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  logic [2:0] mode;
`ifdef FP_MADD_RMODE_EN
  assign mode = r_mode;
`else
  logic unused_rmode;
  assign mode        = 3'd0;
  assign unused_rmode = ^r_mode;
`endif

  // Operand decode; subnormals collapse to zero.
  logic       sa, sb, sc, sp;
  logic [7:0] ea, eb, ec;
  logic [22:0] fa, fb, fc;
  logic a_nan, b_nan, c_nan, a_inf, b_inf, c_inf, a_zero, b_zero, c_zero;
  logic [23:0] ma, mb, mc;

  assign {sa, ea, fa} = fp_a;
  assign {sb, eb, fb} = fp_b;
  assign {sc, ec, fc} = fp_c;
  assign sp = sa ^ sb;

  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign c_nan  = (ec == 8'hFF) && (fc != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign c_inf  = (ec == 8'hFF) && (fc == 23'd0);
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign c_zero = (ec == 8'd0);

  assign ma = a_zero ? 24'd0 : {1'b1, fa};
  assign mb = b_zero ? 24'd0 : {1'b1, fb};
  assign mc = c_zero ? 24'd0 : {1'b1, fc};

  logic [47:0] prod;
  assign prod = {24'd0, ma} * {24'd0, mb};

  logic p_zero, p_inf, invalid, any_nan;
  assign p_zero  = a_zero | b_zero;
  assign p_inf   = a_inf | b_inf;
  assign any_nan = a_nan | b_nan | c_nan;
  assign invalid = (a_inf & b_zero) | (b_inf & a_zero) | (p_inf & c_inf & (sp ^ sc));

  function automatic logic [5:0] lzc52(input logic [51:0] v);
    lzc52 = 6'd52;
    for (int i = 0; i < 52; i++) begin
      if (v[i]) lzc52 = 6'(51 - i);
    end
  endfunction

  // Datapath: both addends carried as 48-bit significands with an LSB exponent.
  logic [47:0]        p_sig, c_sig, x_sig, y_sig;
  logic signed [12:0] p_exp, c_exp, x_exp, y_exp, exp_diff;
  logic               x_is_p, res_sign, zero_sign, eff_sub;
  logic [5:0]         shamt, lz;
  logic [101:0]       y_wide;
  logic [50:0]        x_ext, y_al;
  logic               y_st;
  logic [51:0]        sum, sum_n;
  logic [23:0]        mant;
  logic               guard, sticky, rnd_inc, inf_on_ovf;
  logic [24:0]        mant_r;
  logic [22:0]        frac;
  logic signed [12:0] be, be_r;
  logic [31:0]        result_d, result_q;
  logic               ovf_d, ovf_q, udf_d, udf_q;

  always_comb begin
    p_sig = prod;
    p_exp = $signed({5'd0, ea}) + $signed({5'd0, eb}) - 13'sd300;
    if (!prod[47]) begin
      p_sig = prod << 1;
      p_exp = p_exp - 13'sd1;
    end
    c_sig = {mc, 24'd0};
    c_exp = $signed({5'd0, ec}) - 13'sd174;

    // The larger magnitude becomes x so an effective subtraction never goes negative.
    if (p_zero)                                  x_is_p = 1'b0;
    else if (c_zero)                             x_is_p = 1'b1;
    else if (p_exp > c_exp)                      x_is_p = 1'b1;
    else if ((p_exp == c_exp) && (p_sig >= c_sig)) x_is_p = 1'b1;
    else                                         x_is_p = 1'b0;

    x_sig    = x_is_p ? p_sig : c_sig;
    y_sig    = x_is_p ? c_sig : p_sig;
    x_exp    = x_is_p ? p_exp : c_exp;
    y_exp    = x_is_p ? c_exp : p_exp;
    res_sign = x_is_p ? sp : sc;
    eff_sub  = sp ^ sc;

    exp_diff = x_exp - y_exp;
    if ((exp_diff > 13'sd54) || (exp_diff < 13'sd0)) shamt = 6'd54;
    else                                            shamt = exp_diff[5:0];

    x_ext  = {x_sig, 3'b000};
    y_wide = {y_sig, 3'b000, 51'd0} >> shamt;
    y_al   = y_wide[101:51];
    y_st   = |y_wide[50:0];

    // Shifted-out bits fold into the LSB as a sticky; borrow once for them on subtract.
    if (eff_sub) sum = {1'b0, x_ext} - {1'b0, y_al} - {51'd0, y_st};
    else         sum = {1'b0, x_ext} + {1'b0, y_al};
    sum[0] = sum[0] | y_st;

    lz     = lzc52(sum);
    sum_n  = sum << lz;
    mant   = sum_n[51:28];
    guard  = sum_n[27];
    sticky = |sum_n[26:0];
    be     = x_exp + 13'sd175 - $signed({7'd0, lz});

    case (mode)
      RM_RTZ:  rnd_inc = 1'b0;
      RM_RDN:  rnd_inc = res_sign & (guard | sticky);
      RM_RUP:  rnd_inc = ~res_sign & (guard | sticky);
      RM_RMM:  rnd_inc = guard;
      default: rnd_inc = guard & (sticky | mant[0]);
    endcase

    case (mode)
      RM_RTZ:  inf_on_ovf = 1'b0;
      RM_RDN:  inf_on_ovf = res_sign;
      RM_RUP:  inf_on_ovf = ~res_sign;
      default: inf_on_ovf = 1'b1;
    endcase

    mant_r = {1'b0, mant} + {24'd0, rnd_inc};
    if (mant_r[24]) begin
      frac = mant_r[23:1];
      be_r = be + 13'sd1;
    end else begin
      frac = mant_r[22:0];
      be_r = be;
    end

    // Exact cancellation is +0 except under round-down; like-signed zeros keep their sign.
    zero_sign = (sp == sc) ? sp : (mode == RM_RDN);

    result_d = 32'd0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (any_nan || invalid) begin
      result_d = QNAN;
    end else if (p_inf) begin
      result_d = {sp, 8'hFF, 23'd0};
    end else if (c_inf) begin
      result_d = {sc, 8'hFF, 23'd0};
    end else if (sum == 52'd0) begin
      result_d = {zero_sign, 31'd0};
    end else if (be_r >= 13'sd255) begin
      ovf_d    = 1'b1;
      result_d = inf_on_ovf ? {res_sign, 8'hFF, 23'd0} : {res_sign, 31'h7F7F_FFFF};
    end else if (be_r <= 13'sd0) begin
      udf_d    = 1'b1;
      result_d = {res_sign, 31'd0};
    end else begin
      result_d = {res_sign, be_r[7:0], frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'd0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign fp_result = result_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_fp_madd.sv
// Bench for fp_madd: directed vector table, reset sequences, and random operands
// checked against an exact big-integer model of a*b+c.
module tb_fp_madd;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
`ifdef FP_MADD_RMODE_EN
  localparam bit RM_EN = 1'b1;
`else
  localparam bit RM_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] fp_a, fp_b, fp_c;
  logic [2:0]  r_mode;
  logic [31:0] fp_result;
  logic        overflow, underflow;

  fp_madd #(.QNAN(QNAN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fp_a      (fp_a),
    .fp_b      (fp_b),
    .fp_c      (fp_c),
    .r_mode    (r_mode),
    .fp_result (fp_result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [33:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got res=%h ovf=%b udf=%b, want res=%h ovf=%b udf=%b",
               name, act[33:2], act[1], act[0], exp[33:2], exp[1], exp[0]);
    end
  endtask

  // Drivers
  task automatic drive(input logic [31:0] a, b, c, input logic [2:0] m);
    @(negedge clk);
    fp_a = a; fp_b = b; fp_c = c; r_mode = m;
  endtask

  task automatic step_check(input string name);
    logic [33:0] e;
    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got empty expected queue, want one entry", name);
    end else begin
      n_checks--;
      e = exp_q.pop_front();
      check(name, {fp_result, overflow, underflow}, e);
    end
  endtask

  // Reference model: exact sum as a fixed-point integer with LSB weight 2^-300.
  function automatic logic [33:0] ref_fma(input logic [31:0] a, b, c, input logic [2:0] rm);
    logic sa, sb, sc, sp, sign, inc;
    int ea, eb, ec, k, sh, be, md;
    logic [23:0] ma, mb, mc, q;
    logic [47:0] pp;
    logic [599:0] pm, cm, mag, rem, half, one;
    logic [24:0] q25;
    sa = a[31]; sb = b[31]; sc = c[31]; sp = sa ^ sb;
    ea = int'(a[30:23]); eb = int'(b[30:23]); ec = int'(c[30:23]);
    md = RM_EN ? int'(rm) : 0;
    if (md > 4) md = 0;
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) || (ec == 255 && c[22:0] != 0))
      return {QNAN, 2'b00};
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return {QNAN, 2'b00};
    if (ea == 255 || eb == 255) begin
      if (ec == 255 && sc != sp) return {QNAN, 2'b00};
      return {sp, 8'hFF, 23'd0, 2'b00};
    end
    if (ec == 255) return {sc, 8'hFF, 23'd0, 2'b00};
    ma = (ea == 0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (eb == 0) ? 24'd0 : {1'b1, b[22:0]};
    mc = (ec == 0) ? 24'd0 : {1'b1, c[22:0]};
    pp  = {24'd0, ma} * {24'd0, mb};
    one = 600'd1;
    pm  = 600'(pp) << (ea + eb);
    cm  = 600'(mc) << (ec + 150);
    if (sp == sc) begin mag = pm + cm; sign = sp; end
    else if (pm >= cm) begin mag = pm - cm; sign = sp; end
    else begin mag = cm - pm; sign = sc; end
    if (mag == 0) return {((sp == sc) ? sp : (md == 2)), 31'd0, 2'b00};
    k = 0;
    for (int i = 0; i < 600; i++) if (mag[i]) k = i;
    sh   = k - 23;
    q    = 24'(mag >> sh);
    rem  = mag & ((one << sh) - one);
    half = one << (sh - 1);
    case (md)
      1:       inc = 1'b0;
      2:       inc = sign && (rem != 0);
      3:       inc = !sign && (rem != 0);
      4:       inc = (rem >= half);
      default: inc = (rem > half) || ((rem == half) && q[0]);
    endcase
    q25 = {1'b0, q} + 25'(inc);
    be  = k - 173;
    if (q25[24]) begin q25 = q25 >> 1; be++; end
    if (be >= 255) begin
      if (md == 0 || md == 4 || (md == 2 && sign) || (md == 3 && !sign))
        return {sign, 8'hFF, 23'd0, 2'b10};
      return {sign, 31'h7F7F_FFFF, 2'b10};
    end
    if (be <= 0) return {sign, 31'd0, 2'b01};
    return {sign, 8'(be), q25[22:0], 2'b00};
  endfunction

  typedef struct {
    logic [31:0] a, b, c;
    logic [2:0]  m;
    logic [31:0] res;
    logic        ovf, udf;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] specials [8];

  task automatic add_vec(input logic [31:0] a, b, c, input logic [2:0] m,
                         input logic [31:0] res, input logic ovf, udf);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.m = m; v.res = res; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endtask

  initial begin
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'h0000_0001, 32'h3F80_0000, 32'hFFC1_2345};

    add_vec(32'h3F800000, 32'h40000000, 32'h40400000, 3'd0, 32'h40A00000, 0, 0);
    add_vec(32'h40000000, 32'hC0000000, 32'h40800000, 3'd0, 32'h00000000, 0, 0);
    add_vec(32'h40000000, 32'hC0000000, 32'h40800000, 3'd2, RM_EN ? 32'h80000000 : 32'h0, 0, 0);
    add_vec(32'h40400000, 32'h40000000, 32'hC0A00000, 3'd0, 32'h3F800000, 0, 0);
    add_vec(32'hBF800000, 32'h3F800000, 32'h00000000, 3'd0, 32'hBF800000, 0, 0);
    add_vec(32'h7F800000, 32'h3F800000, 32'h40400000, 3'd0, 32'h7F800000, 0, 0);
    add_vec(32'hFF800000, 32'h40000000, 32'h7F800000, 3'd0, 32'h7FC00000, 0, 0);
    add_vec(32'h7FC00000, 32'h40800000, 32'h40000000, 3'd0, 32'h7FC00000, 0, 0);
    add_vec(32'h3F800000, 32'h40000000, 32'h7FC00000, 3'd0, 32'h7FC00000, 0, 0);
    add_vec(32'h7F000000, 32'h40000000, 32'h00000000, 3'd0, 32'h7F800000, 1, 0);
    add_vec(32'h7F000000, 32'h40000000, 32'h00000000, 3'd1, RM_EN ? 32'h7F7FFFFF : 32'h7F800000, 1, 0);
    add_vec(32'h00800000, 32'h3F000000, 32'h00000000, 3'd0, 32'h00000000, 0, 1);
    add_vec(32'h3F800000, 32'h3F800000, 32'h33800000, 3'd0, 32'h3F800000, 0, 0);
    add_vec(32'h3F800000, 32'h3F800000, 32'h33800000, 3'd4, RM_EN ? 32'h3F800001 : 32'h3F800000, 0, 0);
    add_vec(32'h3F800001, 32'h3F800000, 32'h33800000, 3'd0, 32'h3F800002, 0, 0);
    add_vec(32'h7F800000, 32'h00000000, 32'h3F800000, 3'd0, 32'h7FC00000, 0, 0);
    add_vec(32'h00000001, 32'h3F800000, 32'h80000000, 3'd0, 32'h00000000, 0, 0);
    add_vec(32'h80000000, 32'h3F800000, 32'h80000000, 3'd0, 32'h80000000, 0, 0);
    add_vec(32'h7F000000, 32'hC0000000, 32'h00000000, 3'd3, RM_EN ? 32'hFF7FFFFF : 32'hFF800000, 1, 0);

    // Reset state
    rst_n = 1'b0;
    fp_a = 32'h3F800000; fp_b = 32'h40000000; fp_c = 32'h40400000; r_mode = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {fp_result, overflow, underflow}, 34'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, applied back to back
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].m);
      exp_q.push_back({vecs[i].res, vecs[i].ovf, vecs[i].udf});
      step_check($sformatf("vec%0d", i));
    end

    // Mid-stream reset between edges
    drive(32'h40400000, 32'h40000000, 32'h40400000, 3'd0);
    exp_q.push_back(ref_fma(32'h40400000, 32'h40000000, 32'h40400000, 3'd0));
    step_check("rst_pre");
    #1 rst_n = 1'b0;
    #1 check("rst_async", {fp_result, overflow, underflow}, 34'd0);
    drive(32'h3F800000, 32'h40000000, 32'h40400000, 3'd0);
    @(posedge clk);
    #1 check("rst_hold", {fp_result, overflow, underflow}, 34'd0);
    rst_n = 1'b1;
    drive(32'hC0400000, 32'h40000000, 32'h3F800000, 3'd0);
    exp_q.push_back({32'hC0A00000, 2'b00});
    step_check("rst_post");

    // Random operands against the model
    for (int n = 0; n < 3000; n++) begin : rnd
      int cat;
      logic [31:0] ra, rb, rc;
      logic [2:0] rm;
      cat = int'($urandom_range(0, 9));
      rm  = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom; rc = $urandom;
      case (cat)
        1, 2, 3, 4, 5: begin
          ra[30:23] = 8'($urandom_range(100, 154));
          rb[30:23] = 8'($urandom_range(100, 154));
          rc[30:23] = 8'($urandom_range(90, 164));
        end
        6: begin
          rb = {1'($urandom_range(0, 1)), 8'd127, 23'd0};
          ra[30:23] = 8'($urandom_range(1, 254));
          rc = {~(ra[31] ^ rb[31]), ra[30:23], ra[22:0] ^ 23'($urandom_range(0, 7))};
        end
        7: begin
          ra[30:23] = 8'($urandom_range(190, 254));
          rb[30:23] = 8'($urandom_range(190, 254));
          rc[30:23] = 8'($urandom_range(1, 254));
        end
        8: begin
          ra[30:23] = 8'($urandom_range(1, 70));
          rb[30:23] = 8'($urandom_range(1, 70));
          rc[30:23] = 8'($urandom_range(1, 30));
          if ($urandom_range(0, 3) == 0) rc = 32'd0;
        end
        9: begin
          ra = specials[$urandom_range(0, 7)];
          rb = specials[$urandom_range(0, 7)];
          rc = specials[$urandom_range(0, 7)];
        end
        default: ;
      endcase
      drive(ra, rb, rc, rm);
      exp_q.push_back(ref_fma(ra, rb, rc, rm));
      step_check("rand");
    end

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
